jtpopeye_iobus: RTL and testbench

Z80 I/O-port front end for the Popeye board. It decodes CPU I/O cycles into single-`cen` strobes for the security device and the AY-3-8910 port. It stretches the CPU cycle with `wait_n` until the registered read data is valid, then returns the selected read byte. It also stretches coin pulses so the game loop cannot miss them.

---
 rtl/jtpopeye_pkg.sv | 21 ++
 rtl/jtpopeye_coin.sv | 31 +++
 rtl/jtpopeye_iobus.sv | 174 +++++++++++++++++
 tb/tb_jtpopeye_iobus.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtpopeye_pkg.sv
// Popeye I/O bus shared definitions.
// Port numbers and I/O cycle FSM encoding.
package jtpopeye_pkg;

  localparam logic [2:0] IO_P1      = 3'd0;
  localparam logic [2:0] IO_P2      = 3'd1;
  localparam logic [2:0] IO_SYS     = 3'd2;
  localparam logic [2:0] IO_AY      = 3'd3;
  localparam logic [2:0] IO_SEC0    = 3'd4;
  localparam logic [2:0] IO_SEC1    = 3'd5;
  localparam logic [2:0] IO_AY_ADDR = 3'd0;
  localparam logic [2:0] IO_AY_DATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_CAPTURE,
    ST_DONE
  } io_state_t;

endpackage

// File: rtl/jtpopeye_coin.sv
// Coin pulse stretcher: a falling edge holds the
// active-low output for 2^COIN_W-1 cen ticks.
module jtpopeye_coin #(
  parameter int COIN_W = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic coin_n,
  output logic coin
);

  logic              last;
  logic [COIN_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
      cnt  <= '0;
    end else if (cen) begin
      last <= coin_n;
      if (last && !coin_n)
        cnt <= '1;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  assign coin = (cnt == '0);

endmodule

// File: rtl/jtpopeye_iobus.sv
// Z80 I/O port front end for Popeye: port decode,
// WAIT stretching and peripheral strobes.
module jtpopeye_iobus #(
  parameter int COIN_W = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [2:0] addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic       wait_n,
  input  logic [7:0] p1,
  input  logic [7:0] p2,
  input  logic [1:0] coin_n,
  input  logic [5:0] sys,
  input  logic [7:0] sec_dout,
  output logic [7:0] sec_din,
  output logic       sec_rd_n,
  output logic       sec_wr_n,
  output logic       sec_a0,
  input  logic [7:0] ay_dout,
  output logic [7:0] ay_din,
  output logic       ay_bdir,
  output logic       ay_bc1
);

  import jtpopeye_pkg::*;

  io_state_t  st, st_nx;
  logic       armed;
  logic [2:0] a_q, a_nx;
  logic       wr_q, wr_nx;
  logic [1:0] coin_s;
  logic       valid, is_sec, is_wr;
  logic [7:0] rd_mux;

  logic       wait_nx, srd_nx, swr_nx, a0_nx;
  logic       bdir_nx, bc1_nx;
  logic [7:0] sdin_nx, aydin_nx, din_nx;

  jtpopeye_coin #(.COIN_W(COIN_W)) u_coin0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .coin_n (coin_n[0]),
    .coin   (coin_s[0])
  );

  jtpopeye_coin #(.COIN_W(COIN_W)) u_coin1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .coin_n (coin_n[1]),
    .coin   (coin_s[1])
  );

  // armed blocks a held access from re-running after reset
  assign valid  = armed && !iorq_n && m1_n
               && (!rd_n || !wr_n);
  assign is_sec = (addr[2:1] == 2'b10);
  assign is_wr  = !wr_n;

  always_comb begin
    rd_mux = 8'hFF;
    unique case (a_q)
      IO_P1:   rd_mux = p1;
      IO_P2:   rd_mux = p2;
      IO_SYS:  rd_mux = {sys, coin_s};
      IO_AY:   rd_mux = ay_dout;
      IO_SEC0: rd_mux = sec_dout;
      IO_SEC1: rd_mux = sec_dout;
      default: rd_mux = 8'hFF;
    endcase
  end

  always_comb begin
    st_nx    = st;
    wait_nx  = wait_n;
    srd_nx   = 1'b1;
    swr_nx   = 1'b1;
    bdir_nx  = 1'b0;
    bc1_nx   = 1'b0;
    a0_nx    = sec_a0;
    sdin_nx  = sec_din;
    aydin_nx = ay_din;
    din_nx   = cpu_din;
    a_nx     = a_q;
    wr_nx    = wr_q;
    unique case (st)
      ST_IDLE: if (valid) begin
        st_nx   = ST_STROBE;
        wait_nx = 1'b0;
        a_nx    = addr;
        wr_nx   = is_wr;
        unique case (1'b1)
          (is_wr && is_sec): begin
            swr_nx  = 1'b0;
            a0_nx   = addr[0];
            sdin_nx = cpu_dout;
          end
          (is_wr && addr == IO_AY_ADDR): begin
            bdir_nx  = 1'b1;
            bc1_nx   = 1'b1;
            aydin_nx = cpu_dout;
          end
          (is_wr && addr == IO_AY_DATA): begin
            bdir_nx  = 1'b1;
            aydin_nx = cpu_dout;
          end
          (!is_wr && is_sec): begin
            srd_nx = 1'b0;
            a0_nx  = addr[0];
          end
          (!is_wr && addr == IO_AY):
            bc1_nx = 1'b1;
          default: ;
        endcase
      end
      ST_STROBE:
        st_nx = ST_CAPTURE;
      ST_CAPTURE: begin
        st_nx = ST_DONE;
        if (!wr_q)
          din_nx = rd_mux;
      end
      ST_DONE: begin
        wait_nx = 1'b1;
        if (iorq_n)
          st_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      armed    <= 1'b0;
      a_q      <= '0;
      wr_q     <= 1'b0;
      wait_n   <= 1'b1;
      sec_rd_n <= 1'b1;
      sec_wr_n <= 1'b1;
      sec_a0   <= 1'b0;
      sec_din  <= '0;
      ay_bdir  <= 1'b0;
      ay_bc1   <= 1'b0;
      ay_din   <= '0;
      cpu_din  <= 8'hFF;
    end else if (cen) begin
      st       <= st_nx;
      a_q      <= a_nx;
      wr_q     <= wr_nx;
      wait_n   <= wait_nx;
      sec_rd_n <= srd_nx;
      sec_wr_n <= swr_nx;
      sec_a0   <= a0_nx;
      sec_din  <= sdin_nx;
      ay_bdir  <= bdir_nx;
      ay_bc1   <= bc1_nx;
      ay_din   <= aydin_nx;
      cpu_din  <= din_nx;
      if (iorq_n)
        armed <= 1'b1;
      else if (st == ST_IDLE && valid)
        armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtpopeye_iobus.sv
// Bench for jtpopeye_iobus: scoreboarded I/O cycles
// against a port-map, coin and security-chip model.
module tb_jtpopeye_iobus;

  localparam int CW   = 4;
  localparam int CLEN = (1 << CW) - 1;

  logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b0;
  logic       iorq_n = 1'b1, m1_n = 1'b1;
  logic       rd_n = 1'b1, wr_n = 1'b1;
  logic [2:0] addr = '0;
  logic [7:0] cpu_dout = '0, p1 = '0, p2 = '0;
  logic [7:0] ay_dout = '0;
  logic [1:0] coin_n = 2'b11;
  logic [5:0] sys = '0;
  logic [7:0] sec_dout;
  logic [7:0] cpu_din, sec_din, ay_din;
  logic       wait_n, sec_rd_n, sec_wr_n, sec_a0;
  logic       ay_bdir, ay_bc1;

  jtpopeye_iobus #(.COIN_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .iorq_n(iorq_n), .m1_n(m1_n),
    .rd_n(rd_n), .wr_n(wr_n), .addr(addr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .wait_n(wait_n), .p1(p1), .p2(p2),
    .coin_n(coin_n), .sys(sys),
    .sec_dout(sec_dout), .sec_din(sec_din),
    .sec_rd_n(sec_rd_n), .sec_wr_n(sec_wr_n),
    .sec_a0(sec_a0), .ay_dout(ay_dout),
    .ay_din(ay_din), .ay_bdir(ay_bdir),
    .ay_bc1(ay_bc1)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cen = ($urandom_range(0, 3) != 0);

  int ecnt = 0;
  always @(posedge clk) if (cen) ecnt <= ecnt + 1;

  // security chip: 16-bit shifter with programmable offset
  logic [15:0] sreg = '0;
  logic [2:0]  samt = '0;
  logic [31:0] sx;
  int          nshift = 0;
  always @(posedge clk)
    if (cen && !sec_wr_n) begin
      if (sec_a0) sreg <= {sec_din, sreg[15:8]};
      else        samt <= sec_din[2:0];
      nshift <= nshift + 1;
    end
  assign sx       = {16'h0, sreg} << samt;
  assign sec_dout = sx[15:8];

  int tests = 0, fails = 0;
  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // reference model state
  int         m_lo = 0, m_hi = 0, m_amt = 0;
  int         det0[$], det1[$];
  logic [7:0] last_din = 8'hFF;

  function automatic bit coin_bit(input int i,
                                  input int n);
    if (i == 0) begin
      foreach (det0[j])
        if (det0[j] <= n && n < det0[j] + CLEN)
          return 1'b0;
    end else begin
      foreach (det1[j])
        if (det1[j] <= n && n < det1[j] + CLEN)
          return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] sec_val();
    int v;
    v = ((m_hi * 256 + m_lo) << m_amt) >> 8;
    return 8'(v & 255);
  endfunction

  function automatic logic [7:0] read_model(
      input int port, input int n);
    case (port)
      0: return p1;
      1: return p2;
      2: return {sys, coin_bit(1, n), coin_bit(0, n)};
      3: return ay_dout;
      4, 5: return sec_val();
      default: return 8'hFF;
    endcase
  endfunction

  // {sec_rd_n, sec_wr_n, ay_bdir, ay_bc1}; 4'b1100 = idle
  function automatic logic [3:0] strobe_code(
      input int port, input bit wr);
    if (wr) begin
      if (port == 0) return 4'b1111;
      if (port == 1) return 4'b1110;
      if (port == 4 || port == 5) return 4'b1000;
    end else begin
      if (port == 3) return 4'b1101;
      if (port == 4 || port == 5) return 4'b0100;
    end
    return 4'b1100;
  endfunction

  typedef struct {
    bit         rd;
    logic [7:0] din;
    logic [3:0] code;
    bit         ck_a0;
    bit         a0;
    bit         ck_dat;
    bit         sec;
    logic [7:0] dat;
  } exp_t;
  exp_t sbq[$];

  // monitor: one scoreboard pop per WAIT release
  int         wcnt = 0, scnt = 0, tot_stb = 0;
  logic [3:0] s_code = 4'b1100, code_now;
  logic       s_a0 = 1'b0, wait_d = 1'b1;
  logic [7:0] s_sdat = '0, s_adat = '0;
  exp_t       me;
  always @(posedge clk) begin
    if (!rst_n) begin
      wcnt = 0; scnt = 0; wait_d = 1'b1;
    end else begin
      if (wait_n && !wait_d) begin
        if (sbq.size() == 0)
          chk("unexpected_done", sbq.size(), 1);
        else begin
          me = sbq.pop_front();
          chk("wait_len", wcnt, 3);
          chk("strobe_cnt", scnt,
              {31'd0, me.code != 4'b1100});
          if (me.code != 4'b1100)
            chk("strobe_code", {28'd0, s_code},
                {28'd0, me.code});
          chk(me.rd ? "read_din" : "hold_din",
              {24'd0, cpu_din}, {24'd0, me.din});
          if (me.ck_a0)
            chk("sec_a0", {31'd0, s_a0}, {31'd0, me.a0});
          if (me.ck_dat)
            chk("wr_data",
                {24'd0, me.sec ? s_sdat : s_adat},
                {24'd0, me.dat});
        end
        wcnt = 0; scnt = 0;
      end
      if (cen && !wait_n) wcnt++;
      code_now = {sec_rd_n, sec_wr_n, ay_bdir, ay_bc1};
      if (cen && code_now != 4'b1100) begin
        scnt++; tot_stb++;
        s_code = code_now; s_a0 = sec_a0;
        s_sdat = sec_din; s_adat = ay_din;
      end
      wait_d = wait_n;
    end
  end

  task automatic wait_cen();
    int i = 0;
    do begin
      @(posedge clk); i++;
    end while (!cen && i < 1000);
    @(negedge clk);
  endtask

  task automatic access(input int port, input bit wr,
                        input bit both,
                        input logic [7:0] data,
                        input int hold);
    exp_t e;
    int   n;
    bit   ok, seen;
    wait_cen();
    n        = ecnt + 2;
    e.rd     = !wr;
    e.code   = strobe_code(port, wr);
    e.ck_a0  = (port == 4 || port == 5);
    e.a0     = port[0];
    e.ck_dat = wr && e.code != 4'b1100;
    e.sec    = port[2];
    e.dat    = data;
    if (!wr) last_din = read_model(port, n);
    else if (port == 4) m_amt = data & 7;
    else if (port == 5) begin
      m_lo = m_hi; m_hi = data;
    end
    e.din = last_din;
    sbq.push_back(e);
    addr = port[2:0]; cpu_dout = data;
    m1_n = 1'b1; iorq_n = 1'b0;
    rd_n = (wr && !both); wr_n = !wr;
    ok = 0; seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (seen && wait_n) begin ok = 1; break; end
      if (!wait_n) seen = 1;
    end
    chk("access_done", {31'd0, ok}, 1);
    repeat (hold) wait_cen();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    wait_cen(); wait_cen();
  endtask

  task automatic coin_pulse(input int i);
    wait_cen();
    coin_n[i] = 1'b0;
    if (i == 0) det0.push_back(ecnt + 1);
    else        det1.push_back(ecnt + 1);
    wait_cen();
    coin_n[i] = 1'b1;
  endtask

  initial begin
    int  s0, d0, port;
    bit  wr, both, allhi, saw, second;
    repeat (4) @(negedge clk);
    chk("rst_cpu_din", {24'd0, cpu_din}, 32'hFF);
    chk("rst_ctl", {26'd0, wait_n, sec_rd_n, sec_wr_n,
                    sec_a0, ay_bdir, ay_bc1}, 32'h38);
    chk("rst_data", {16'd0, sec_din, ay_din}, 0);
    rst_n = 1'b1;
    repeat (4) wait_cen();

    s0 = nshift;
    access(4, 1, 0, 8'h03, 0);
    access(5, 1, 0, 8'h81, 0);
    access(5, 1, 0, 8'h42, 0);
    chk("sec_three_shifts", nshift - s0, 3);
    access(4, 0, 0, 8'h00, 0);

    p1 = 8'h5A; p2 = 8'hA5; sys = 6'h2A; ay_dout = 8'h3C;
    access(0, 0, 0, 8'h00, 0);
    access(1, 0, 0, 8'h00, 0);
    access(2, 0, 0, 8'h00, 0);
    access(3, 0, 0, 8'h00, 0);
    access(6, 0, 0, 8'h00, 0);

    wait_cen();
    s0 = tot_stb; allhi = 1;
    iorq_n = 1'b0; m1_n = 1'b0;
    repeat (10) begin wait_cen(); allhi &= wait_n; end
    chk("inta_wait", {31'd0, allhi}, 1);
    chk("inta_strobes", tot_stb - s0, 0);
    chk("inta_din", {24'd0, cpu_din}, {24'd0, last_din});
    iorq_n = 1'b1; m1_n = 1'b1;
    wait_cen(); wait_cen();

    s0 = nshift;
    access(5, 1, 0, 8'h77, 20);
    chk("hold_shifts", nshift - s0, 1);

    wait_cen();
    s0 = nshift; saw = 0;
    addr = 3'd4; cpu_dout = 8'h05;
    iorq_n = 1'b0; wr_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!sec_wr_n) begin saw = 1; break; end
    end
    chk("rst_reach_strobe", {31'd0, saw}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {29'd0, wait_n, sec_wr_n,
                        sec_rd_n}, 7);
    chk("rst_mid_din", {24'd0, cpu_din}, 32'hFF);
    last_din = 8'hFF;
    det0.delete(); det1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1; allhi = 1;
    repeat (8) begin wait_cen(); allhi &= wait_n; end
    chk("rst_no_rerun", {31'd0, allhi}, 1);
    chk("rst_no_shift", nshift - s0, 0);
    iorq_n = 1'b1; wr_n = 1'b1;
    wait_cen(); wait_cen();
    access(4, 0, 0, 8'h00, 0);

    coin_pulse(0);
    d0 = det0[det0.size() - 1];
    second = 0;
    while (ecnt < d0 + 40) begin
      access(2, 0, 0, 8'h00, 0);
      if (!second && ecnt >= d0 + 7) begin
        coin_pulse(0); second = 1;
      end
    end
    coin_pulse(1);
    repeat (4) access(2, 0, 0, 8'h00, 0);

    for (int t = 0; t < 60; t++) begin
      port = $urandom_range(0, 7);
      wr   = $urandom_range(0, 1);
      both = wr && ($urandom_range(0, 7) == 0);
      p1 = 8'($urandom); p2 = 8'($urandom);
      sys = 6'($urandom); ay_dout = 8'($urandom);
      access(port, wr, both, 8'($urandom), 0);
    end

    repeat (4) wait_cen();
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
